// File: rtl/regfile_debug_master_pkg.sv
// Shared definitions for the register-file debug master.
// Holds the regfile write-command encodings, special file addresses,
// debug FSM state encodings and the latched command record.
package regfile_debug_master_pkg;

    localparam int DBG_CMD_WIDTH = 7;

    // Regfile writeCommand encodings.
    localparam logic [2:0] RF_WR________NOP = 3'd0;  // no write
    localparam logic [2:0] RF_WR________FSR = 3'd1;  // write FSR directly
    localparam logic [2:0] RF_WR_FSR____IND = 3'd2;  // write fileAddr (INDF resolves through FSR)

    // Special file addresses.
    localparam logic [4:0] ADDR_INDF  = 5'h00;
    localparam logic [4:0] ADDR_TMR0  = 5'h01;
    localparam logic [4:0] ADDR_PCL   = 5'h02;
    localparam logic [4:0] ADDR_FSR   = 5'h04;
    localparam logic [4:0] ADDR_PORTC = 5'h07;

    typedef enum logic [2:0] {
        DBG_ST_IDLE      = 3'd0,
        DBG_ST_WAIT_HALT = 3'd1,
        DBG_ST_SAVE      = 3'd2,
        DBG_ST_SETBANK   = 3'd3,
        DBG_ST_ACCESS    = 3'd4,
        DBG_ST_RESTORE   = 3'd5,
        DBG_ST_RESPOND   = 3'd6
    } dbg_state_e;

    typedef struct packed {
        logic       write;
        logic [1:0] bank;
        logic [4:0] file_addr;
        logic [7:0] data;
    } dbg_cmd_t;

    // Only the upper half of the file space (0x10-0x1F) is banked by FSR[6:5].
    function automatic logic is_banked(input logic [4:0] file_addr);
        return file_addr[4];
    endfunction

endpackage

// File: rtl/regfile_debug_master_if.sv
// Bundle of the debug command/response link, halt handshake and regfile port.
// master: the debug master block; slave: its environment (debug front end,
// core halt logic and register file).
interface regfile_debug_master_if;
    import regfile_debug_master_pkg::*;

    logic                     cmdValid;
    logic                     cmdReady;
    logic                     cmdWrite;
    logic [DBG_CMD_WIDTH-1:0] cmdAddr;
    logic [7:0]               cmdData;
    logic                     rspValid;
    logic                     rspReady;
    logic [7:0]               rspData;
    logic                     rspErr;
    logic                     haltReq;
    logic                     haltAck;
    logic [2:0]               rfWriteCmd;
    logic [4:0]               rfFileAddr;
    logic [7:0]               rfWriteData;
    logic [7:0]               rfFsrIn;
    logic [7:0]               rfRegfileIn;

    modport master (
        input  cmdValid, cmdWrite, cmdAddr, cmdData, rspReady, haltAck, rfFsrIn, rfRegfileIn,
        output cmdReady, rspValid, rspData, rspErr, haltReq, rfWriteCmd, rfFileAddr, rfWriteData
    );

    modport slave (
        output cmdValid, cmdWrite, cmdAddr, cmdData, rspReady, haltAck, rfFsrIn, rfRegfileIn,
        input  cmdReady, rspValid, rspData, rspErr, haltReq, rfWriteCmd, rfFileAddr, rfWriteData
    );
endinterface

// File: rtl/regfile_debug_master_dbg_halt_timer.sv
// Purpose: counts cycles spent waiting for haltAck; expire flags the last allowed cycle.
// Latency: expire is decoded from the count register (no input-to-output path).
// Backpressure: none; counting saturates at expiry until cleared.
// Ports: clk, rst (sync, active-low), clear, enable, expire.
module dbg_halt_timer #(
    parameter int WIDTH = 7,
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    logic [WIDTH-1:0] count;

    assign expire = (count == WIDTH'(LIMIT - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expire) begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/regfile_debug_master.sv
// Purpose: replays single debug read/write commands onto the regfile port while the core is halted.
// Latency: response 4 cycles after accept with haltAck already high, 6 when an FSR bank switch is needed.
// Backpressure: one command in flight; cmdReady only in IDLE, response held until rspReady.
// Ports: clk, rst (sync, active-low), bus (master modport: cmd/rsp link, halt handshake, regfile port).
module regfile_debug_master
    import regfile_debug_master_pkg::*;
#(
    parameter int HALT_TIMEOUT = 64,
    parameter int TMR_WIDTH    = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    regfile_debug_master_if.master bus
);
    dbg_state_e state;
    dbg_cmd_t   cmd;
    logic       need_bank;
    logic [7:0] saved_fsr;

    logic       cmd_ready;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       halt_req;
    logic [2:0] rf_write_cmd;
    logic [4:0] rf_file_addr;
    logic [7:0] rf_write_data;

    logic       accept;
    logic       timer_en;
    logic       timer_expire;
    logic [2:0] access_cmd;

    assign accept     = (state == DBG_ST_IDLE) && cmd_ready && bus.cmdValid;
    assign timer_en   = (state == DBG_ST_WAIT_HALT) && !bus.haltAck;
    assign access_cmd = cmd.write ? RF_WR_FSR____IND : RF_WR________NOP;

    dbg_halt_timer #(
        .WIDTH (TMR_WIDTH),
        .LIMIT (HALT_TIMEOUT)
    ) u_halt_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (accept),
        .enable (timer_en),
        .expire (timer_expire)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= DBG_ST_IDLE;
            cmd           <= '0;
            need_bank     <= 1'b0;
            saved_fsr     <= 8'h00;
            cmd_ready     <= 1'b1;
            rsp_valid     <= 1'b0;
            rsp_data      <= 8'h00;
            rsp_err       <= 1'b0;
            halt_req      <= 1'b0;
            rf_write_cmd  <= RF_WR________NOP;
            rf_file_addr  <= 5'h00;
            rf_write_data <= 8'h00;
        end else begin
            case (state)
                DBG_ST_IDLE: begin
                    if (accept) begin
                        cmd <= '{write: bus.cmdWrite, bank: bus.cmdAddr[6:5],
                                 file_addr: bus.cmdAddr[4:0], data: bus.cmdData};
                        cmd_ready <= 1'b0;
                        halt_req  <= 1'b1;
                        rsp_data  <= 8'h00;
                        rsp_err   <= 1'b0;
                        state     <= DBG_ST_WAIT_HALT;
                    end
                end
                DBG_ST_WAIT_HALT: begin
                    if (bus.haltAck) begin
                        state <= DBG_ST_SAVE;
                    end else if (timer_expire) begin
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= DBG_ST_RESPOND;
                    end
                end
                DBG_ST_SAVE: begin
                    saved_fsr <= bus.rfFsrIn;
                    // Live FSR is used here because saved_fsr only updates at this edge.
                    if (is_banked(cmd.file_addr) && (cmd.bank != bus.rfFsrIn[6:5])) begin
                        need_bank     <= 1'b1;
                        rf_write_cmd  <= RF_WR________FSR;
                        rf_write_data <= {bus.rfFsrIn[7], cmd.bank, bus.rfFsrIn[4:0]};
                        state         <= DBG_ST_SETBANK;
                    end else begin
                        need_bank     <= 1'b0;
                        rf_file_addr  <= cmd.file_addr;
                        rf_write_cmd  <= access_cmd;
                        rf_write_data <= cmd.data;
                        state         <= DBG_ST_ACCESS;
                    end
                end
                DBG_ST_SETBANK: begin
                    rf_file_addr  <= cmd.file_addr;
                    rf_write_cmd  <= access_cmd;
                    rf_write_data <= cmd.data;
                    state         <= DBG_ST_ACCESS;
                end
                DBG_ST_ACCESS: begin
                    if (!cmd.write) begin
                        rsp_data <= bus.rfRegfileIn;
                    end
                    // A debug write to FSR becomes the value to keep. Banked accesses never
                    // target FSR, so RESTORE below can safely use the pre-access saved_fsr.
                    if (cmd.write && (cmd.file_addr == ADDR_FSR)) begin
                        saved_fsr <= cmd.data;
                    end
                    if (need_bank) begin
                        rf_write_cmd  <= RF_WR________FSR;
                        rf_write_data <= saved_fsr;
                        state         <= DBG_ST_RESTORE;
                    end else begin
                        rf_write_cmd <= RF_WR________NOP;
                        rsp_valid    <= 1'b1;
                        state        <= DBG_ST_RESPOND;
                    end
                end
                DBG_ST_RESTORE: begin
                    rf_write_cmd <= RF_WR________NOP;
                    rsp_valid    <= 1'b1;
                    state        <= DBG_ST_RESPOND;
                end
                DBG_ST_RESPOND: begin
                    if (bus.rspReady) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        halt_req  <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= DBG_ST_IDLE;
                    end
                end
                default: begin
                    state <= DBG_ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cmdReady    = cmd_ready;
    assign bus.rspValid    = rsp_valid;
    assign bus.rspData     = rsp_data;
    assign bus.rspErr      = rsp_err;
    assign bus.haltReq     = halt_req;
    assign bus.rfWriteCmd  = rf_write_cmd;
    assign bus.rfFileAddr  = rf_file_addr;
    assign bus.rfWriteData = rf_write_data;
endmodule

// File: tb/tb_regfile_debug_master.sv
// Directed bench for regfile_debug_master with a small behavioural register file:
// FSR, 16 low files, 4 banks of 16 GPRs, PORTC input fixed at 0x5A, TMR0/PCL writes ignored.
module tb_regfile_debug_master;
    import regfile_debug_master_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    regfile_debug_master_if bus();

    regfile_debug_master #(
        .HALT_TIMEOUT (64),
        .TMR_WIDTH    (7)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- register file model ----------------
    logic [7:0] fsr = 8'h00;
    logic [7:0] gpr [64] = '{default: 8'h00};
    logic [7:0] low [16] = '{default: 8'h00};
    logic [7:0] fsr_log [16];
    int         fsr_wr_cnt = 0;
    int         ind_wr_cnt = 0;
    logic [4:0] rf_addr;
    logic [7:0] rd;

    assign rf_addr = (bus.rfFileAddr == 5'h00) ? fsr[4:0] : bus.rfFileAddr;

    always_comb begin
        rd = 8'h00;
        if (rf_addr == 5'h04)      rd = fsr;
        else if (rf_addr == 5'h07) rd = 8'h5A;
        else if (rf_addr[4])       rd = gpr[{fsr[6:5], rf_addr[3:0]}];
        else                       rd = low[rf_addr[3:0]];
    end

    assign bus.rfFsrIn     = fsr;
    assign bus.rfRegfileIn = rd;

    always @(posedge clk) begin
        if (bus.rfWriteCmd == RF_WR________FSR) begin
            fsr <= bus.rfWriteData;
            fsr_log[fsr_wr_cnt[3:0]] <= bus.rfWriteData;
            fsr_wr_cnt <= fsr_wr_cnt + 1;
        end else if (bus.rfWriteCmd == RF_WR_FSR____IND) begin
            ind_wr_cnt <= ind_wr_cnt + 1;
            if (rf_addr == 5'h04)                          fsr <= bus.rfWriteData;
            else if (rf_addr[4])                           gpr[{fsr[6:5], rf_addr[3:0]}] <= bus.rfWriteData;
            else if (rf_addr != 5'h01 && rf_addr != 5'h02) low[rf_addr[3:0]] <= bus.rfWriteData;
        end
    end

    // ---------------- stimulus helpers ----------------
    // Issues one command; lat = posedges from the accept edge (inclusive) until rspValid.
    task automatic send(input logic wr, input logic [6:0] addr, input logic [7:0] data,
                        output int lat);
        int n;
        n = 0;
        while (!bus.cmdReady && n < 100) begin @(negedge clk); n++; end
        bus.cmdValid = 1'b1;
        bus.cmdWrite = wr;
        bus.cmdAddr  = addr;
        bus.cmdData  = data;
        @(negedge clk);
        bus.cmdValid = 1'b0;
        n = 1;
        while (!bus.rspValid && n < 200) begin @(negedge clk); n++; end
        lat = n;
    endtask

    task automatic consume();
        bus.rspReady = 1'b1;
        @(negedge clk);
        bus.rspReady = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (bus.cmdReady !== 1'b1) begin bad++; $display("FAIL reset_cmdReady: got %b want 1", bus.cmdReady); end
        total++; if (bus.rspValid !== 1'b0) begin bad++; $display("FAIL reset_rspValid: got %b want 0", bus.rspValid); end
        total++; if (bus.rspData !== 8'h00 || bus.rspErr !== 1'b0) begin bad++; $display("FAIL reset_rsp: got data=%h err=%b want 00/0", bus.rspData, bus.rspErr); end
        total++; if (bus.haltReq !== 1'b0) begin bad++; $display("FAIL reset_haltReq: got %b want 0", bus.haltReq); end
        total++; if (bus.rfWriteCmd !== RF_WR________NOP || bus.rfFileAddr !== 5'h00 || bus.rfWriteData !== 8'h00) begin
            bad++; $display("FAIL reset_rf: got cmd=%0d addr=%h data=%h want 0/00/00", bus.rfWriteCmd, bus.rfFileAddr, bus.rfWriteData); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read_portc();
        int lat, f0, i0;
        f0 = fsr_wr_cnt; i0 = ind_wr_cnt;
        send(1'b0, 7'h07, 8'h00, lat);
        total++; if (lat !== 4) begin bad++; $display("FAIL portc_latency: got %0d want 4", lat); end
        total++; if (bus.rspData !== 8'h5A || bus.rspErr !== 1'b0) begin bad++; $display("FAIL portc_data: got %h err=%b want 5a/0", bus.rspData, bus.rspErr); end
        total++; if (fsr_wr_cnt - f0 !== 0 || ind_wr_cnt - i0 !== 0) begin bad++; $display("FAIL portc_no_writes: got fsr=%0d ind=%0d want 0/0", fsr_wr_cnt - f0, ind_wr_cnt - i0); end
        consume();
    endtask

    task automatic test_bank_write();
        int lat, f0, i0;
        f0 = fsr_wr_cnt; i0 = ind_wr_cnt;
        send(1'b1, 7'h35, 8'hC3, lat);
        total++; if (lat !== 6) begin bad++; $display("FAIL bankwr_latency: got %0d want 6", lat); end
        total++; if (fsr_wr_cnt - f0 !== 2 || fsr_log[f0[3:0]] !== 8'h20 || fsr_log[4'(f0 + 1)] !== 8'h00) begin
            bad++; $display("FAIL bankwr_fsr_seq: got n=%0d %h,%h want 2 20,00", fsr_wr_cnt - f0, fsr_log[f0[3:0]], fsr_log[4'(f0 + 1)]); end
        total++; if (ind_wr_cnt - i0 !== 1 || gpr[6'h15] !== 8'hC3) begin bad++; $display("FAIL bankwr_gpr: got n=%0d val=%h want 1/c3", ind_wr_cnt - i0, gpr[6'h15]); end
        total++; if (bus.rspData !== 8'h00) begin bad++; $display("FAIL bankwr_rspData: got %h want 00", bus.rspData); end
        consume();
        send(1'b0, 7'h35, 8'h00, lat);
        total++; if (lat !== 6 || bus.rspData !== 8'hC3) begin bad++; $display("FAIL bankrd_back: got lat=%0d data=%h want 6/c3", lat, bus.rspData); end
        consume();
        total++; if (fsr !== 8'h00) begin bad++; $display("FAIL bankrd_fsr_restored: got %h want 00", fsr); end
    endtask

    task automatic test_fsr_write();
        int lat, f0;
        f0 = fsr_wr_cnt;
        send(1'b1, 7'h04, 8'h7F, lat);
        total++; if (lat !== 4 || bus.rspData !== 8'h00) begin bad++; $display("FAIL fsrwr_rsp: got lat=%0d data=%h want 4/00", lat, bus.rspData); end
        consume();
        total++; if (fsr !== 8'h7F || fsr_wr_cnt !== f0) begin bad++; $display("FAIL fsrwr_value: got fsr=%h restores=%0d want 7f/0", fsr, fsr_wr_cnt - f0); end
        // Bank 11 live, bank 01 requested: switch to 0x3F, restore to 0x7F.
        f0 = fsr_wr_cnt;
        send(1'b0, 7'h35, 8'h00, lat);
        total++; if (lat !== 6 || bus.rspData !== 8'hC3) begin bad++; $display("FAIL fsr7f_read: got lat=%0d data=%h want 6/c3", lat, bus.rspData); end
        consume();
        total++; if (fsr_log[f0[3:0]] !== 8'h3F || fsr_log[4'(f0 + 1)] !== 8'h7F || fsr !== 8'h7F) begin
            bad++; $display("FAIL fsr7f_seq: got %h,%h fsr=%h want 3f,7f fsr=7f", fsr_log[f0[3:0]], fsr_log[4'(f0 + 1)], fsr); end
    endtask

    task automatic test_indf();
        int lat;
        send(1'b1, 7'h04, 8'h36, lat); consume();
        send(1'b1, 7'h00, 8'h4E, lat);
        total++; if (lat !== 4) begin bad++; $display("FAIL indf_latency: got %0d want 4", lat); end
        consume();
        total++; if (gpr[6'h16] !== 8'h4E) begin bad++; $display("FAIL indf_target: got %h want 4e", gpr[6'h16]); end
        send(1'b1, 7'h04, 8'h00, lat); consume();
        send(1'b0, 7'h36, 8'h00, lat);
        total++; if (lat !== 6 || bus.rspData !== 8'h4E) begin bad++; $display("FAIL indf_readback: got lat=%0d data=%h want 6/4e", lat, bus.rspData); end
        consume();
    endtask

    task automatic test_back_to_back();
        int lat;
        send(1'b1, 7'h08, 8'hA5, lat); consume();
        total++; if (bus.cmdReady !== 1'b1 || bus.haltReq !== 1'b0) begin bad++; $display("FAIL b2b_idle: got ready=%b halt=%b want 1/0", bus.cmdReady, bus.haltReq); end
        send(1'b0, 7'h08, 8'h00, lat);
        total++; if (lat !== 4 || bus.rspData !== 8'hA5) begin bad++; $display("FAIL b2b_read: got lat=%0d data=%h want 4/a5", lat, bus.rspData); end
        consume();
        send(1'b1, 7'h01, 8'h99, lat);
        total++; if (lat !== 4 || bus.rspErr !== 1'b0 || bus.rspData !== 8'h00) begin bad++; $display("FAIL tmr0_write: got lat=%0d err=%b data=%h want 4/0/00", lat, bus.rspErr, bus.rspData); end
        consume();
    endtask

    task automatic test_timeout();
        int lat, f0, i0;
        f0 = fsr_wr_cnt; i0 = ind_wr_cnt;
        bus.haltAck = 1'b0;
        // 64 cycles in WAIT_HALT, then RESPOND: visible after the 65th edge.
        send(1'b1, 7'h10, 8'h11, lat);
        total++; if (lat !== 65) begin bad++; $display("FAIL timeout_latency: got %0d want 65", lat); end
        total++; if (bus.rspErr !== 1'b1 || bus.rspData !== 8'h00) begin bad++; $display("FAIL timeout_rsp: got err=%b data=%h want 1/00", bus.rspErr, bus.rspData); end
        total++; if (fsr_wr_cnt !== f0 || ind_wr_cnt !== i0) begin bad++; $display("FAIL timeout_no_writes: got fsr=%0d ind=%0d want 0/0", fsr_wr_cnt - f0, ind_wr_cnt - i0); end
        consume();
        total++; if (bus.rspErr !== 1'b0 || bus.cmdReady !== 1'b1) begin bad++; $display("FAIL timeout_clear: got err=%b ready=%b want 0/1", bus.rspErr, bus.cmdReady); end
        bus.haltAck = 1'b1;
    endtask

    task automatic test_backpressure();
        int lat;
        send(1'b0, 7'h07, 8'h00, lat);
        for (int k = 0; k < 10; k++) begin
            total++;
            if (bus.rspValid !== 1'b1 || bus.rspData !== 8'h5A || bus.haltReq !== 1'b1 || bus.cmdReady !== 1'b0) begin
                bad++; $display("FAIL hold_cycle%0d: got vld=%b data=%h halt=%b rdy=%b want 1/5a/1/0", k, bus.rspValid, bus.rspData, bus.haltReq, bus.cmdReady);
            end
            @(negedge clk);
        end
        consume();
        total++; if (bus.rspValid !== 1'b0 || bus.haltReq !== 1'b0 || bus.cmdReady !== 1'b1) begin
            bad++; $display("FAIL hold_release: got vld=%b halt=%b rdy=%b want 0/0/1", bus.rspValid, bus.haltReq, bus.cmdReady); end
    endtask

    task automatic test_reset_mid();
        int n, lat;
        bus.cmdValid = 1'b1; bus.cmdWrite = 1'b1; bus.cmdAddr = 7'h35; bus.cmdData = 8'h66;
        @(negedge clk);
        bus.cmdValid = 1'b0;
        n = 0;
        while (bus.rfWriteCmd !== RF_WR________FSR && n < 20) begin @(negedge clk); n++; end
        total++; if (bus.rfWriteCmd !== RF_WR________FSR) begin bad++; $display("FAIL midrst_setbank: got cmd=%0d want %0d", bus.rfWriteCmd, RF_WR________FSR); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (bus.cmdReady !== 1'b1 || bus.rspValid !== 1'b0 || bus.haltReq !== 1'b0) begin
            bad++; $display("FAIL midrst_handshake: got rdy=%b vld=%b halt=%b want 1/0/0", bus.cmdReady, bus.rspValid, bus.haltReq); end
        total++; if (bus.rfWriteCmd !== RF_WR________NOP || bus.rfFileAddr !== 5'h00 || bus.rfWriteData !== 8'h00 || bus.rspData !== 8'h00) begin
            bad++; $display("FAIL midrst_rf: got cmd=%0d addr=%h wd=%h rd=%h want 0/00/00/00", bus.rfWriteCmd, bus.rfFileAddr, bus.rfWriteData, bus.rspData); end
        rst = 1'b1;
        @(negedge clk);
        send(1'b1, 7'h04, 8'h00, lat);
        total++; if (lat !== 4) begin bad++; $display("FAIL postrst_cmd: got lat=%0d want 4", lat); end
        consume();
    endtask

    initial begin
        bus.cmdValid = 1'b0;
        bus.cmdWrite = 1'b0;
        bus.cmdAddr  = 7'h00;
        bus.cmdData  = 8'h00;
        bus.rspReady = 1'b0;
        bus.haltAck  = 1'b1;
        @(negedge clk);
        test_reset();
        test_read_portc();
        test_bank_write();
        test_fsr_write();
        test_indf();
        test_back_to_back();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
